// File: rtl/oled_spi_sink.sv
// ST7735 SPI receive model: decodes csn/clk/mosi/dc into command pulses and windowed RAMWR pixel strobes.
// Latency: byte registered 3 clk after oled_clk high is first sampled; cmd_valid/pixel_valid one clk later.
// No backpressure: outputs are fire-and-forget pulses. Optional MADCTL mirroring with `define OLED_SINK_MADCTL_EN.
module oled_spi_sink #(
    parameter int C_x_size = 128,
    parameter int C_y_size = 160
) (
    input  logic        clk,
    input  logic        resn,
    input  logic        oled_csn,
    input  logic        oled_clk,
    input  logic        oled_mosi,
    input  logic        oled_dc,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic        pixel_valid,
    output logic [6:0]  x,
    output logic [7:0]  y,
    output logic [15:0] color
);

    localparam logic [7:0] X_LAST = 8'(C_x_size - 1);
    localparam logic [7:0] Y_LAST = 8'(C_y_size - 1);
    localparam logic [8:0] X_LIM  = 9'(C_x_size);
    localparam logic [8:0] Y_LIM  = 9'(C_y_size);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_MADCTL,
        S_OTHER
    } state_t;

    // input synchronisers and byte assembly
    logic       csn_s1_q, csn_s1_d, csn_s2_q, csn_s2_d;
    logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic       mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic       dc_s1_q, dc_s1_d, dc_s2_q, dc_s2_d;
    logic [6:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       byte_vld_q, byte_vld_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_dc_q, byte_dc_d;
    logic       rise;

    // command decode and pixel stream
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [7:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic        half_q, half_d;
    logic [7:0]  hi_q, hi_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic [6:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [15:0] color_q, color_d;
    logic        in_panel;
`ifdef OLED_SINK_MADCTL_EN
    logic        mx_q, mx_d, my_q, my_d;
`endif

    always_comb begin
        csn_s1_d   = oled_csn;
        csn_s2_d   = csn_s1_q;
        clk_s1_d   = oled_clk;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        mosi_s1_d  = oled_mosi;
        mosi_s2_d  = mosi_s1_q;
        dc_s1_d    = oled_dc;
        dc_s2_d    = dc_s1_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        byte_dc_d  = byte_dc_q;
        rise       = clk_s2_q & ~clk_prev_q;
        if (csn_s2_q) begin
            cnt_d = 3'd0;
        end else if (rise) begin
            sr_d  = {sr_q[5:0], mosi_s2_q};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                byte_vld_d = 1'b1;
                byte_d     = {sr_q, mosi_s2_q};
                byte_dc_d  = dc_s2_q;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        xs_d          = xs_q;
        xe_d          = xe_q;
        ys_d          = ys_q;
        ye_d          = ye_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        half_d        = half_q;
        hi_d          = hi_q;
        cmd_valid_d   = 1'b0;
        cmd_d         = cmd_q;
        pixel_valid_d = 1'b0;
        x_d           = x_q;
        y_d           = y_q;
        color_d       = color_q;
        in_panel      = ({1'b0, cur_x_q} < X_LIM) && ({1'b0, cur_y_q} < Y_LIM);
`ifdef OLED_SINK_MADCTL_EN
        mx_d          = mx_q;
        my_d          = my_q;
`endif
        if (byte_vld_q && !byte_dc_q) begin
            cmd_valid_d = 1'b1;
            cmd_d       = byte_q;
            idx_d       = 3'd0;
            half_d      = 1'b0;
            case (byte_q)
                8'h2A: state_d = S_CASET;
                8'h2B: state_d = S_RASET;
                8'h2C: begin
                    state_d = S_RAMWR;
                    cur_x_d = xs_q;
                    cur_y_d = ys_q;
                end
`ifdef OLED_SINK_MADCTL_EN
                8'h36: state_d = S_MADCTL;
`endif
                default: state_d = S_OTHER;
            endcase
        end else if (byte_vld_q) begin
            if (idx_q != 3'd4) begin
                idx_d = idx_q + 3'd1;
            end
            case (state_q)
                S_CASET: begin
                    if (idx_q == 3'd1) xs_d = byte_q;
                    if (idx_q == 3'd3) xe_d = byte_q;
                end
                S_RASET: begin
                    if (idx_q == 3'd1) ys_d = byte_q;
                    if (idx_q == 3'd3) ye_d = byte_q;
                end
`ifdef OLED_SINK_MADCTL_EN
                S_MADCTL: begin
                    if (idx_q == 3'd0) begin
                        my_d = byte_q[7];
                        mx_d = byte_q[6];
                    end
                end
`endif
                S_RAMWR: begin
                    if (!half_q) begin
                        hi_d   = byte_q;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        // out-of-panel pixels are dropped but still consume a position
                        if (in_panel) begin
                            pixel_valid_d = 1'b1;
                            color_d       = {hi_q, byte_q};
`ifdef OLED_SINK_MADCTL_EN
                            x_d = mx_q ? 7'(X_LAST - cur_x_q) : cur_x_q[6:0];
                            y_d = my_q ? (Y_LAST - cur_y_q) : cur_y_q;
`else
                            x_d = cur_x_q[6:0];
                            y_d = cur_y_q;
`endif
                        end
                        if (cur_x_q == xe_q) begin
                            cur_x_d = xs_q;
                            cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 8'd1;
                        end else begin
                            cur_x_d = cur_x_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            csn_s1_q      <= 1'b1;
            csn_s2_q      <= 1'b1;
            clk_s1_q      <= 1'b0;
            clk_s2_q      <= 1'b0;
            clk_prev_q    <= 1'b0;
            mosi_s1_q     <= 1'b0;
            mosi_s2_q     <= 1'b0;
            dc_s1_q       <= 1'b0;
            dc_s2_q       <= 1'b0;
            sr_q          <= 7'd0;
            cnt_q         <= 3'd0;
            byte_vld_q    <= 1'b0;
            byte_q        <= 8'd0;
            byte_dc_q     <= 1'b0;
            state_q       <= S_IDLE;
            idx_q         <= 3'd0;
            xs_q          <= 8'd0;
            xe_q          <= X_LAST;
            ys_q          <= 8'd0;
            ye_q          <= Y_LAST;
            cur_x_q       <= 8'd0;
            cur_y_q       <= 8'd0;
            half_q        <= 1'b0;
            hi_q          <= 8'd0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= 8'd0;
            pixel_valid_q <= 1'b0;
            x_q           <= 7'd0;
            y_q           <= 8'd0;
            color_q       <= 16'd0;
`ifdef OLED_SINK_MADCTL_EN
            mx_q          <= 1'b0;
            my_q          <= 1'b0;
`endif
        end else begin
            csn_s1_q      <= csn_s1_d;
            csn_s2_q      <= csn_s2_d;
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            clk_prev_q    <= clk_prev_d;
            mosi_s1_q     <= mosi_s1_d;
            mosi_s2_q     <= mosi_s2_d;
            dc_s1_q       <= dc_s1_d;
            dc_s2_q       <= dc_s2_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            byte_vld_q    <= byte_vld_d;
            byte_q        <= byte_d;
            byte_dc_q     <= byte_dc_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            xs_q          <= xs_d;
            xe_q          <= xe_d;
            ys_q          <= ys_d;
            ye_q          <= ye_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            half_q        <= half_d;
            hi_q          <= hi_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_q         <= cmd_d;
            pixel_valid_q <= pixel_valid_d;
            x_q           <= x_d;
            y_q           <= y_d;
            color_q       <= color_d;
`ifdef OLED_SINK_MADCTL_EN
            mx_q          <= mx_d;
            my_q          <= my_d;
`endif
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd         = cmd_q;
    assign pixel_valid = pixel_valid_q;
    assign x           = x_q;
    assign y           = y_q;
    assign color       = color_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Bench for oled_spi_sink (default build): directed + random SPI traffic, expected pulses
// come from a byte-level model of the display protocol and are checked by an independent monitor.
module tb_oled_spi_sink;

    logic        clk;
    logic        resn;
    logic        oled_csn;
    logic        oled_clk;
    logic        oled_mosi;
    logic        oled_dc;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic        pixel_valid;
    logic [6:0]  x;
    logic [7:0]  y;
    logic [15:0] color;

    oled_spi_sink #(.C_x_size(128), .C_y_size(160)) dut (
        .clk         (clk),
        .resn        (resn),
        .oled_csn    (oled_csn),
        .oled_clk    (oled_clk),
        .oled_mosi   (oled_mosi),
        .oled_dc     (oled_dc),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .pixel_valid (pixel_valid),
        .x           (x),
        .y           (y),
        .color       (color)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          is_pix;
        logic [7:0]  cmd;
        logic [6:0]  x;
        logic [7:0]  y;
        logic [15:0] color;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // reference model state: what an ST7735 would hold after the bytes seen so far
    int          m_mode;   // 0 idle/other, 1 caset, 2 raset, 3 ramwr
    int          m_idx;
    int          m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
    bit          m_half;
    logic [7:0]  m_hi;
    logic [6:0]  last_x;
    logic [7:0]  last_y;
    logic [15:0] last_color;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_idx = 0; m_half = 0; m_hi = 8'h00;
        m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 159; m_cx = 0; m_cy = 0;
        last_x = 7'd0; last_y = 8'd0; last_color = 16'h0000;
    endtask

    task automatic model_byte(input bit dc, input logic [7:0] b);
        exp_t e;
        if (!dc) begin
            e.is_pix = 0; e.cmd = b; e.x = 7'd0; e.y = 8'd0; e.color = 16'h0;
            q.push_back(e);
            m_idx = 0;
            m_half = 0;
            if (b == 8'h2A)      m_mode = 1;
            else if (b == 8'h2B) m_mode = 2;
            else if (b == 8'h2C) begin m_mode = 3; m_cx = m_xs; m_cy = m_ys; end
            else                 m_mode = 0;
        end else begin
            if (m_mode == 1 && m_idx == 1) m_xs = int'(b);
            if (m_mode == 1 && m_idx == 3) m_xe = int'(b);
            if (m_mode == 2 && m_idx == 1) m_ys = int'(b);
            if (m_mode == 2 && m_idx == 3) m_ye = int'(b);
            m_idx++;
            if (m_mode == 3) begin
                if (!m_half) begin
                    m_hi = b; m_half = 1;
                end else begin
                    m_half = 0;
                    if (m_cx < 128 && m_cy < 160) begin
                        e.is_pix = 1; e.cmd = 8'h00;
                        e.x = 7'(m_cx); e.y = 8'(m_cy); e.color = {m_hi, b};
                        q.push_back(e);
                    end
                    if (m_cx == m_xe) begin
                        m_cx = m_xs;
                        m_cy = (m_cy == m_ye) ? m_ys : (m_cy + 1) % 256;
                    end else begin
                        m_cx = (m_cx + 1) % 256;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resn && (cmd_valid || pixel_valid)) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_pulse actual=cmd_valid:%0b,pixel_valid:%0b required=none at %0t",
                         cmd_valid, pixel_valid, $time);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", 32'({pixel_valid, cmd_valid}), e.is_pix ? 32'd2 : 32'd1);
                if (e.is_pix) begin
                    chk("pix_x", 32'(x), 32'(e.x));
                    chk("pix_y", 32'(y), 32'(e.y));
                    chk("pix_color", 32'(color), 32'(e.color));
                    last_x = e.x; last_y = e.y; last_color = e.color;
                end else begin
                    chk("cmd", 32'(cmd), 32'(e.cmd));
                    chk("x_hold", 32'(x), 32'(last_x));
                    chk("y_hold", 32'(y), 32'(last_y));
                    chk("color_hold", 32'(color), 32'(last_color));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit dc, input bit b);
        oled_clk  = 1'b0;
        oled_mosi = b;
        oled_dc   = dc;
        wait_clk(3);
        oled_clk = 1'b1;
        wait_clk(3);
    endtask

    task automatic send_byte(input bit dc, input logic [7:0] b);
        model_byte(dc, b);
        oled_csn = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(dc, b[i]);
        oled_clk = 1'b0;
        wait_clk(3);
    endtask

    task automatic csn_high();
        oled_clk = 1'b0;
        oled_csn = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_pixel(input logic [15:0] c);
        send_byte(1'b1, c[15:8]);
        send_byte(1'b1, c[7:0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_cmd"}, 32'(cmd), 32'd0);
        chk({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_color"}, 32'(color), 32'd0);
    endtask

    task automatic send_window(input logic [7:0] c, input logic [7:0] lo0, input logic [7:0] lo1);
        send_byte(1'b0, c);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, lo0);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, lo1);
    endtask

    initial begin
        int r, n;
        logic [7:0] b;
        resn = 1'b0; oled_csn = 1'b1; oled_clk = 1'b0; oled_mosi = 1'b0; oled_dc = 1'b0;
        m_reset();
        wait_clk(4);
        resn = 1'b1;
        wait_clk(2);
        check_reset_outputs("reset");

        // plain command
        send_byte(1'b0, 8'h01);
        csn_high();

        // window wrap in both axes
        send_window(8'h2A, 8'd2, 8'd3);
        send_window(8'h2B, 8'd5, 8'd6);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) send_pixel(16'hF800);
        csn_high();

        // partial byte dropped by csn
        oled_csn = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'(i & 1));
        csn_high();
        send_byte(1'b0, 8'h2C);

        // clip at the right panel edge
        send_window(8'h2A, 8'h7F, 8'h80);
        send_byte(1'b0, 8'h2C);
        send_pixel(16'h1234);
        send_pixel(16'h5678);

        // abort a half pixel with a new RAMWR
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12);
        send_byte(1'b0, 8'h2C);
        send_pixel(16'h3456);

        // 0x36 is just another command in this build
        send_byte(1'b0, 8'h36);
        send_byte(1'b1, 8'h40);
        send_byte(1'b0, 8'h2C);
        send_pixel(16'hABCD);
        csn_high();

        // reset mid-pixel and mid-byte
        send_window(8'h2A, 8'd10, 8'd20);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h99);
        oled_csn = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        wait_clk(2);
        chk("queue_empty_before_reset", 32'(q.size()), 32'd0);
        resn = 1'b0;
        wait_clk(1);
        check_reset_outputs("midreset");
        oled_csn = 1'b1; oled_clk = 1'b0;
        wait_clk(4);
        resn = 1'b1;
        m_reset();
        wait_clk(4);
        send_byte(1'b0, 8'h2C);
        send_pixel(16'h0F0F);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                send_byte(1'b0, (r <= 1) ? 8'h2A : 8'h2B);
                n = $urandom_range(0, 5);
                for (int i = 0; i < n; i++) begin
                    b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(100, 170));
                    send_byte(1'b1, b);
                end
            end else if (r <= 7) begin
                send_byte(1'b0, 8'h2C);
                n = $urandom_range(0, 12);
                for (int i = 0; i < n; i++) send_byte(1'b1, 8'($urandom_range(0, 255)));
            end else if (r == 8) begin
                send_byte(1'b0, 8'($urandom_range(0, 255)));
                n = $urandom_range(0, 3);
                for (int i = 0; i < n; i++) send_byte(1'b1, 8'($urandom_range(0, 255)));
            end else begin
                csn_high();
            end
        end

        csn_high();
        for (int i = 0; i < 20 && q.size() != 0; i++) wait_clk(1);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
